// File: rtl/umix_bus_arbiter.sv
// umix_bus_arbiter: round-robin owner selection for the shared register/memory input buses.
// Registered one-hot grants, forced dead cycles between owners, optional max-hold preemption.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   req      in   [N_REQ] level request per master, held for the whole transaction
//   gnt      out  [N_REQ] one-hot-or-zero grant, drives that master's buf enables
//   owner    out  index of the current grantee, meaningful while busy=1
//   busy     out  1 while any gnt bit is set
//   preempt  out  1-cycle pulse when a grant is withdrawn by max-hold expiry
module umix_bus_arbiter #(
    parameter int N_REQ    = 3,
    parameter int TURN     = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     preempt
);

    localparam int OW = $clog2(N_REQ);
    localparam int CW = OW + 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int TW = 2;

    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_TURN
    } state_t;

    state_t            state_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [OW-1:0]     owner_q;
    logic [OW-1:0]     rr_q;
    logic              busy_q;
    logic              preempt_q;
    logic [HW-1:0]     hold_q;
    logic [TW-1:0]     turn_q;

    logic [OW-1:0]     win;
    logic              found;
    logic [CW-1:0]     cand;
    logic              others;
    logic              expire;
    logic              drop;
    logic              arb_now;

    // Search rr_q+1, rr_q+2, ... wrapping at N_REQ; first requester wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = CW'(rr_q) + CW'(i + 1);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && req[cand[OW-1:0]]) begin
                found = 1'b1;
                win   = cand[OW-1:0];
            end
        end
    end

    // gnt_q is one-hot on the owner, so masking with it leaves the waiters.
    assign others  = |(req & ~gnt_q);
    assign expire  = (MAX_HOLD != 0) && (hold_q == HW'(MAX_HOLD - 1)) && others;
    assign drop    = !req[owner_q] || expire;
    assign arb_now = (state_q == ST_IDLE) ||
                     ((state_q == ST_TURN) && (turn_q == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            rr_q      <= OW'(N_REQ - 1);
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            turn_q    <= '0;
        end else begin
            preempt_q <= 1'b0;
            unique case (state_q)
                ST_GRANT: begin
                    if (hold_q != HW'(MAX_HOLD)) begin
                        hold_q <= hold_q + 1'b1;
                    end
                    if (drop) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= ST_TURN;
                        turn_q    <= TW'(TURN - 1);
                        // A simultaneous release wins over expiry: no pulse.
                        preempt_q <= req[owner_q];
                    end
                end
                ST_TURN: begin
                    if (turn_q != '0) begin
                        turn_q <= turn_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
            // rr_q keeps the last owner through TURN so it goes to the back.
            if (arb_now) begin
                if (found) begin
                    gnt_q   <= ONE << win;
                    owner_q <= win;
                    rr_q    <= win;
                    busy_q  <= 1'b1;
                    hold_q  <= '0;
                    state_q <= ST_GRANT;
                end else begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
